// File: rtl/icache_sa_pkg.sv
// Shared definitions for the icache_sa instruction cache: default word width,
// refill FSM encoding and a field-width helper.
package icache_sa_pkg;

  localparam int WORD_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Width of a field selecting among n items, never narrower than one bit.
  function automatic int field_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and line data array, each with a
// single write port and an asynchronous (combinational) read.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 4,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [OFF_W-1:0]     rd_off,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 data_we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [OFF_W-1:0]     wr_off,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 tag_we,
  input  logic [IDX_W-1:0]     tag_idx,
  input  logic [TAG_W-1:0]     wr_tag
);

  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [WORD_SIZE-1:0] data_mem [SETS][LINE_WORDS];

  // NOTE: non-blocking (<=) for every register so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[tag_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid bits alone qualify their contents,
  // which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[tag_idx] <= wr_tag;
    if (data_we) data_mem[wr_idx][wr_off] <= wr_data;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_off];

endmodule

// File: rtl/icache_sa.sv
// icache_sa: 1- or 2-way set-associative instruction cache with blocking line
// refill and LRU replacement. Define ICACHE_STATS_EN to add hit/miss counters.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] ptr,
  input  logic                 rd_en,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] out,
  output logic                 hit,
  output logic                 stall,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int OFF_W    = field_w(LINE_WORDS);
  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = WORD_SIZE - OFF_BITS - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e               state;
  logic [OFF_W-1:0]     beat;
  logic                 victim_q;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic [SETS-1:0]      lru;  // per set: index of the least recently used way

  logic [OFF_W-1:0]     req_off;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;

  logic                 way_valid [WAYS];
  logic [TAG_W-1:0]     way_tag   [WAYS];
  logic [WORD_SIZE-1:0] way_data  [WAYS];
  logic [WAYS-1:0]      way_data_we;
  logic [WAYS-1:0]      way_tag_we;

  logic                 hit_any;
  logic                 hit_way;
  logic [WORD_SIZE-1:0] hit_word;
  logic                 victim;
  logic                 start_fill;

  assign req_off = OFF_W'(ptr & WORD_SIZE'(LINE_WORDS - 1));
  assign req_idx = IDX_W'(ptr >> OFF_BITS);
  assign req_tag = TAG_W'(ptr >> (OFF_BITS + IDX_W));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_data_we[w] = (state == FILL) && mem_ack && !flush && (victim_q == 1'(w));
    assign way_tag_we[w]  = (state == COMMIT) && !flush && (victim_q == 1'(w));

    icache_way #(
      .WORD_SIZE  (WORD_SIZE),
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .rd_idx   (req_idx),
      .rd_off   (req_off),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .data_we  (way_data_we[w]),
      .wr_idx   (fill_idx),
      .wr_off   (beat),
      .wr_data  (mem_data),
      .tag_we   (way_tag_we[w]),
      .tag_idx  (fill_idx),
      .wr_tag   (fill_tag)
    );
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && way_valid[w] && (way_tag[w] == req_tag)) begin
        hit_any  = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_data[w];
      end
    end
  end

  // Fill an empty way first (way 0 preferred); only evict when the set is full.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2 && way_valid[0]) begin
      victim = way_valid[WAYS-1] ? lru[req_idx] : 1'b1;
    end
  end

  assign hit        = !rst && (state == IDLE) && rd_en && !flush && hit_any;
  assign out        = hit ? hit_word : '0;
  assign start_fill = !rst && (state == IDLE) && rd_en && !flush && !hit_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      victim_q <= 1'b0;
      fill_idx <= '0;
      fill_tag <= '0;
      lru      <= '0;
      stall    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (hit && WAYS == 2) lru[req_idx] <= ~hit_way;
      unique case (state)
        IDLE: begin
          if (start_fill) begin
            state    <= FILL;
            beat     <= '0;
            victim_q <= victim;
            fill_idx <= req_idx;
            fill_tag <= req_tag;
            stall    <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= ptr & ~WORD_SIZE'(LINE_WORDS - 1);
          end
        end
        FILL: begin
          if (flush) begin
            state    <= IDLE;
            beat     <= '0;
            stall    <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end else if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              state    <= COMMIT;
              mem_req  <= 1'b0;
              mem_addr <= '0;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          beat  <= '0;
          stall <= 1'b0;
          // The just-filled way becomes most recently used unless the fill is aborted.
          if (!flush && WAYS == 2) lru[fill_idx] <= ~victim_q;
        end
        default: begin
          state    <= IDLE;
          stall    <= 1'b0;
          mem_req  <= 1'b0;
          mem_addr <= '0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (start_fill && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
